boot_load_ctrl: RTL and testbench

- Sequences SoC start-up from the UART: takes received bytes from the UART receiver, parses a framed program image and writes it word-by-word into instruction/data memory through a valid/ready write port.
- Holds the core in reset for the whole load and releases it once the image is written and, optionally, verified.
- Sits between the UART RX path and the memory write port of `soc`; the top-level TinyTapeout wrapper drives its clock and reset.

---
 rtl/boot_load_ctrl.sv | 156 +++++++++++++++
 tb/tb_boot_load_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_load_ctrl.sv
// UART boot loader: parses an A5/LEN/payload frame into 32-bit memory writes, then releases the core.
// Optional trailing XOR checksum byte is enabled by defining BOOT_CHECKSUM_EN.
module boot_load_ctrl #(
   parameter int unsigned       ADDR_W         = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
   parameter int unsigned       TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              mem_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   output logic              core_rst,
   output logic              boot_done,
   output logic [1:0]        err_code
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LEN_LO = 3'd1;
   localparam logic [2:0] LEN_HI = 3'd2;
   localparam logic [2:0] DATA   = 3'd3;
   localparam logic [2:0] CSUM   = 3'd4;
   localparam logic [2:0] FINISH = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;
   localparam logic [2:0] ERROR  = 3'd7;

   localparam logic [7:0] SYNC = 8'hA5;

`ifdef BOOT_CHECKSUM_EN
   localparam logic [2:0] AFTER_DATA = CSUM;
`else
   localparam logic [2:0] AFTER_DATA = FINISH;
`endif

   logic [2:0]       state;
   logic [7:0]       len_lo;
   logic [15:0]      words_left;
   logic [1:0]       byte_idx;
   logic [23:0]      asm_word;
   logic [CNT_W-1:0] idle_cnt;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]       csum;
`endif

   logic        accept;
   logic        timing;
   logic        timeout;
   logic        sync_seen;
   logic [15:0] n_words;

   always_comb begin
      accept    = mem_valid & mem_ready;
      timing    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
      // A byte arriving on the terminal count wins over the timeout.
      timeout   = timing && !rx_valid && (idle_cnt == CNT_W'(TIMEOUT_CYCLES));
      sync_seen = rx_valid && (rx_data == SYNC);
      n_words   = {rx_data, len_lo};
   end

   assign core_rst  = (state != DONE);
   assign boot_done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         len_lo     <= '0;
         words_left <= '0;
         byte_idx   <= '0;
         asm_word   <= '0;
         idle_cnt   <= '0;
         mem_valid  <= 1'b0;
         mem_addr   <= BASE_ADDR;
         mem_wdata  <= '0;
         err_code   <= 2'd0;
`ifdef BOOT_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         if (accept) begin
            mem_valid <= 1'b0;
            mem_addr  <= mem_addr + ADDR_W'(4);
         end

         if (!timing || rx_valid || timeout) idle_cnt <= '0;
         else                                idle_cnt <= idle_cnt + CNT_W'(1);

         if (timeout) begin
            state     <= ERROR;
            err_code  <= 2'd3;
            mem_valid <= 1'b0;
         end else begin
            case (state)
               IDLE, ERROR: begin
                  if (sync_seen) begin
                     state    <= LEN_LO;
                     err_code <= 2'd0;
                     mem_addr <= BASE_ADDR;
                     byte_idx <= '0;
`ifdef BOOT_CHECKSUM_EN
                     csum     <= '0;
`endif
                  end
               end
               LEN_LO: if (rx_valid) begin
                  len_lo <= rx_data;
                  state  <= LEN_HI;
               end
               LEN_HI: if (rx_valid) begin
                  words_left <= n_words;
                  state      <= (n_words != 16'd0) ? DATA : AFTER_DATA;
               end
               DATA: if (rx_valid) begin
                  byte_idx <= byte_idx + 2'd1;
                  asm_word <= {rx_data, asm_word[23:8]};
`ifdef BOOT_CHECKSUM_EN
                  csum     <= csum ^ rx_data;
`endif
                  if (byte_idx == 2'd3) begin
                     if (mem_valid && !mem_ready) begin
                        // Previous word still stalled: abort and drop it.
                        state     <= ERROR;
                        err_code  <= 2'd2;
                        mem_valid <= 1'b0;
                     end else begin
                        mem_valid  <= 1'b1;
                        mem_wdata  <= {rx_data, asm_word};
                        words_left <= words_left - 16'd1;
                        if (words_left == 16'd1) state <= AFTER_DATA;
                     end
                  end
               end
`ifdef BOOT_CHECKSUM_EN
               CSUM: if (rx_valid) begin
                  if (rx_data == csum) begin
                     state <= FINISH;
                  end else begin
                     state     <= ERROR;
                     err_code  <= 2'd1;
                     mem_valid <= 1'b0;
                  end
               end
`endif
               FINISH: if (!mem_valid) state <= DONE;
               DONE: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Self-checking bench for boot_load_ctrl; write scoreboard compares expected vs observed writes.
// Checksum scenarios are included when BOOT_CHECKSUM_EN is defined.
module tb_boot_load_ctrl;

   localparam int unsigned       ADDR_W  = 16;
   localparam logic [15:0]       BASE    = 16'hFFFC;
   localparam int unsigned       TIMEOUT = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        mem_valid;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b1;
   logic        core_rst;
   logic        boot_done;
   logic [1:0]  err_code;

   int n_checks = 0;
   int n_fail = 0;

   logic [47:0] exp_q[$];
   logic [47:0] obs_q[$];
   logic [15:0] exp_addr;

   boot_load_ctrl #(
      .ADDR_W(ADDR_W),
      .BASE_ADDR(BASE),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .mem_valid(mem_valid),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ready(mem_ready),
      .core_rst(core_rst),
      .boot_done(boot_done),
      .err_code(err_code)
   );

   always #5 clk = ~clk;

   // Record every accepted write, sampled mid-low-phase.
   always begin
      @(negedge clk);
      #2;
      if (rst_n && mem_valid && mem_ready) obs_q.push_back({mem_addr, mem_wdata});
   end

   task automatic do_reset();
      rst_n = 1'b0;
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      obs_q.delete();
      exp_addr = BASE;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit expect_write);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
      if (expect_write) begin
         exp_q.push_back({exp_addr, w});
         exp_addr = exp_addr + 16'd4;
      end
   endtask

   task automatic send_csum(input logic [7:0] b);
`ifdef BOOT_CHECKSUM_EN
      send_byte(b);
`endif
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60 && !boot_done; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_checks += 6;
      if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", mem_valid); end
      if (mem_addr !== BASE) begin n_fail++; $display("FAIL reset_addr: got %h want %h", mem_addr, BASE); end
      if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
      if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
      if (boot_done !== 1'b0) begin n_fail++; $display("FAIL reset_boot_done: got %b want 0", boot_done); end
      if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", err_code); end
   endtask

   task automatic test_clean_load();
      logic [47:0] e, o;
      do_reset();
      mem_ready = 1'b1;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_word(32'h44332211, 1'b1);
      send_word(32'h88776655, 1'b1);
      send_csum(8'h88);
      wait_done();
      n_checks += 4;
      if (boot_done !== 1'b1) begin n_fail++; $display("FAIL clean_done: got %b want 1", boot_done); end
      if (core_rst !== 1'b0) begin n_fail++; $display("FAIL clean_core_rst: got %b want 0", core_rst); end
      if (err_code !== 2'd0) begin n_fail++; $display("FAIL clean_err: got %0d want 0", err_code); end
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL clean_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL clean_write: got %h want %h", o, e); end
      end
   endtask

   task automatic test_back_pressure();
      logic [47:0] e, o;
      int bad;
      do_reset();
      mem_ready = 1'b0;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_word(32'h44332211, 1'b1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_valid !== 1'b1 || mem_addr !== BASE || mem_wdata !== 32'h44332211) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
      mem_ready = 1'b1;
      send_word(32'h88776655, 1'b1);
      send_csum(8'h88);
      wait_done();
      n_checks += 3;
      if (boot_done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b want 1", boot_done); end
      if (err_code !== 2'd0) begin n_fail++; $display("FAIL bp_err: got %0d want 0", err_code); end
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL bp_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL bp_write: got %h want %h", o, e); end
      end
   endtask

   task automatic test_overrun();
      do_reset();
      mem_ready = 1'b0;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_word(32'h44332211, 1'b0);
      send_word(32'h88776655, 1'b0);
      @(negedge clk);
      n_checks += 3;
      if (err_code !== 2'd2) begin n_fail++; $display("FAIL ovr_err: got %0d want 2", err_code); end
      if (core_rst !== 1'b1) begin n_fail++; $display("FAIL ovr_core_rst: got %b want 1", core_rst); end
      if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid: got %b want 0", mem_valid); end
      mem_ready = 1'b1;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      send_csum(8'h00);
      wait_done();
      n_checks += 3;
      if (boot_done !== 1'b1) begin n_fail++; $display("FAIL ovr_recover_done: got %b want 1", boot_done); end
      if (err_code !== 2'd0) begin n_fail++; $display("FAIL ovr_recover_err: got %0d want 0", err_code); end
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL ovr_writes: got %0d want 0", obs_q.size()); end
   endtask

   task automatic test_timeout();
      do_reset();
      mem_ready = 1'b1;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
      repeat (TIMEOUT - 5) @(negedge clk);
      n_checks++;
      if (err_code !== 2'd0) begin n_fail++; $display("FAIL to_early: got %0d want 0", err_code); end
      for (int i = 0; i < 20 && err_code != 2'd3; i++) @(negedge clk);
      n_checks += 4;
      if (err_code !== 2'd3) begin n_fail++; $display("FAIL to_err: got %0d want 3", err_code); end
      if (core_rst !== 1'b1) begin n_fail++; $display("FAIL to_core_rst: got %b want 1", core_rst); end
      if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL to_valid: got %b want 0", mem_valid); end
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL to_writes: got %0d want 0", obs_q.size()); end
   endtask

`ifdef BOOT_CHECKSUM_EN
   task automatic test_checksum();
      logic [47:0] e, o;
      do_reset();
      mem_ready = 1'b1;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_word(32'h04030201, 1'b1);
      send_byte(8'h05);
      repeat (5) @(negedge clk);
      n_checks += 4;
      if (err_code !== 2'd1) begin n_fail++; $display("FAIL cs_err: got %0d want 1", err_code); end
      if (core_rst !== 1'b1) begin n_fail++; $display("FAIL cs_core_rst: got %b want 1", core_rst); end
      if (boot_done !== 1'b0) begin n_fail++; $display("FAIL cs_done: got %b want 0", boot_done); end
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL cs_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL cs_write: got %h want %h", o, e); end
      end
   endtask
`endif

   task automatic test_noise_zero_len();
      do_reset();
      mem_ready = 1'b1;
      send_byte(8'h00); send_byte(8'hFF);
      n_checks++;
      if (core_rst !== 1'b1) begin n_fail++; $display("FAIL noise_core_rst: got %b want 1", core_rst); end
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      send_csum(8'h00);
      wait_done();
      n_checks += 2;
      if (boot_done !== 1'b1) begin n_fail++; $display("FAIL zlen_done: got %b want 1", boot_done); end
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL zlen_writes: got %0d want 0", obs_q.size()); end
   endtask

   task automatic test_mid_reset();
      logic [47:0] e, o;
      do_reset();
      mem_ready = 1'b0;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_word(32'hDEADBEEF, 1'b0);
      send_byte(8'h55);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks += 5;
      if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid: got %b want 0", mem_valid); end
      if (mem_addr !== BASE) begin n_fail++; $display("FAIL mr_addr: got %h want %h", mem_addr, BASE); end
      if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL mr_wdata: got %h want 0", mem_wdata); end
      if (core_rst !== 1'b1) begin n_fail++; $display("FAIL mr_core_rst: got %b want 1", core_rst); end
      if (err_code !== 2'd0) begin n_fail++; $display("FAIL mr_err: got %0d want 0", err_code); end
      do_reset();
      mem_ready = 1'b1;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_word(32'hCAFEF00D, 1'b1);
      send_csum(8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D);
      wait_done();
      n_checks += 2;
      if (boot_done !== 1'b1) begin n_fail++; $display("FAIL mr_done: got %b want 1", boot_done); end
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL mr_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL mr_write: got %h want %h", o, e); end
      end
   endtask

   initial begin
      test_reset();
      test_clean_load();
      test_back_pressure();
      test_overrun();
      test_timeout();
`ifdef BOOT_CHECKSUM_EN
      test_checksum();
`endif
      test_noise_zero_len();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
